// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and defaults for the SRAM bus arbiter
//
// Contents:
//   ADDR_W_DEF / DATA_W_DEF  default address and data widths
//   RST_ENABLE               active level of rst
//   arb_state_e              arbiter FSM states
//   is_if_state()            true while the bus is owned by instruction fetch
package bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IF_ADDR  = 3'd1,
        IF_DATA  = 3'd2,
        MEM_ADDR = 3'd3,
        MEM_DATA = 3'd4
    } arb_state_e;

    function automatic logic is_if_state(input arb_state_e s);
        return (s == IF_ADDR) || (s == IF_DATA);
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// rtl/sram_bus_arbiter_if.sv - SRAM-like memory bus between arbiter and memory slave
//
// Signals:
//   req      address-phase valid (arbiter -> slave)
//   we       1 = store, 0 = load
//   sel      byte enables, DATA_W/8 bits
//   addr     access address
//   wdata    store data
//   addr_ok  slave accepted the address this cycle
//   data_ok  slave completed the data phase this cycle
//   rdata    read data, valid with data_ok
// Modports: master (arbiter side), slave (memory side).
interface sram_bus_arbiter_if
    import bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic                  req;
    logic                  we;
    logic [DATA_W/8-1:0]   sel;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, we, sel, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, we, sel, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/arb_port_hold.sv
// rtl/arb_port_hold.sv - per-requester completion flag and read-data holding register
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   set_done   access completed this cycle (wins over clr_done)
//   clr_done   owning pipeline stage advances this cycle
//   load       capture data_in into the holding register
//   data_in    read data from the bus
//   done       completion flag, held until the stage advances
//   rdata      last captured read data
module arb_port_hold
    import bus_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_done,
    input  logic              clr_done,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              done,
    output logic [DATA_W-1:0] rdata
);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            done  <= 1'b0;
            rdata <= '0;
        end else begin
            if (set_done) begin
                done <= 1'b1;
            end else if (clr_done) begin
                done <= 1'b0;
            end
            if (load) begin
                rdata <= data_in;
            end
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - shares one SRAM-like bus between instruction fetch and data access
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall[5:0]               pipeline stall vector, [pc,if,id,ex,mem,wb] = bits [0..5]
//   flush                    cancels an outstanding fetch
//   if_req/if_addr           fetch request, held until if_stallreq drops
//   if_rdata/if_stallreq     fetched word and fetch stall request
//   mem_req/we/sel/addr/wdata data request, held until mem_stallreq drops
//   mem_rdata/mem_stallreq   load data and data stall request
//   bus                      master side of the memory bus
//
// Each access is an address phase (req held until addr_ok) followed by a data
// phase (wait for data_ok). MEM wins over IF when both are pending in IDLE.
module sram_bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stallreq,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [DATA_W/8-1:0] mem_sel,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_stallreq,
    sram_bus_arbiter_if.master  bus
);

    localparam int SEL_W = DATA_W / 8;

    arb_state_e          state;
    logic                bus_req_q;
    logic                bus_we_q;
    logic [SEL_W-1:0]    bus_sel_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic                discard;

    logic                if_done;
    logic                mem_done;

    logic                mem_grant;
    logic                if_grant;
    logic                if_complete;
    logic                if_keep;
    logic                mem_complete;

    // Only the IF and MEM advance bits matter here.
    logic                unused_stall;
    assign unused_stall = &{1'b0, stall[0], stall[3:2], stall[5]};

    assign mem_grant    = (state == IDLE) && mem_req && !mem_done;
    assign if_grant     = (state == IDLE) && !mem_grant && if_req && !if_done;
    assign if_complete  = (state == IF_DATA) && bus.data_ok;
    assign mem_complete = (state == MEM_DATA) && bus.data_ok;
    // A fetch flushed earlier (discard) or in its completion cycle is dropped.
    assign if_keep      = if_complete && !discard && !flush;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state       <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            discard     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_grant) begin
                        state       <= MEM_ADDR;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_we;
                        bus_sel_q   <= mem_sel;
                        bus_addr_q  <= mem_addr;
                        bus_wdata_q <= mem_wdata;
                    end else if (if_grant) begin
                        state      <= IF_ADDR;
                        bus_req_q  <= 1'b1;
                        bus_we_q   <= 1'b0;
                        bus_sel_q  <= '1;
                        bus_addr_q <= if_addr;
                    end
                end
                IF_ADDR, MEM_ADDR: begin
                    if (bus.addr_ok) begin
                        bus_req_q <= 1'b0;
                        state     <= (state == IF_ADDR) ? IF_DATA : MEM_DATA;
                    end
                end
                IF_DATA, MEM_DATA: begin
                    if (bus.data_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus_req_q <= 1'b0;
                end
            endcase

            // The bus access cannot be aborted, so a flushed fetch still runs
            // to data_ok; discard remembers to drop its result.
            if (if_complete) begin
                discard <= 1'b0;
            end else if (flush && is_if_state(state)) begin
                discard <= 1'b1;
            end
        end
    end

    assign bus.req   = bus_req_q;
    assign bus.we    = bus_we_q;
    assign bus.sel   = bus_sel_q;
    assign bus.addr  = bus_addr_q;
    assign bus.wdata = bus_wdata_q;

    arb_port_hold #(.DATA_W(DATA_W)) u_if_hold (
        .clk      (clk),
        .rst      (rst),
        .set_done (if_keep),
        .clr_done (!stall[1] || flush),
        .load     (if_keep),
        .data_in  (bus.rdata),
        .done     (if_done),
        .rdata    (if_rdata)
    );

    // Stores complete without touching the load-data register.
    arb_port_hold #(.DATA_W(DATA_W)) u_mem_hold (
        .clk      (clk),
        .rst      (rst),
        .set_done (mem_complete),
        .clr_done (!stall[4]),
        .load     (mem_complete && !bus_we_q),
        .data_in  (bus.rdata),
        .done     (mem_done),
        .rdata    (mem_rdata)
    );

    assign if_stallreq  = if_req && !if_done;
    assign mem_stallreq = mem_req && !mem_done;

endmodule
